// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin snooping-bus arbiter for three processors with writeback and memory sequencing.
module bus_arbiter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [1:0] req_cmd0,
  input  logic [1:0] req_cmd1,
  input  logic [1:0] req_cmd2,
  input  logic [4:0] req_addr0,
  input  logic [4:0] req_addr1,
  input  logic [4:0] req_addr2,
  output logic [2:0] gnt,
  output logic       bus_valid,
  output logic [1:0] bus_cmd,
  output logic [4:0] bus_addr,
  output logic [1:0] bus_owner,
  input  logic [2:0] snoop_share,
  input  logic [2:0] snoop_wb,
  input  logic [7:0] wb_data,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [2:0] done,
  output logic [7:0] rdata,
  output logic       shared
);
  typedef enum logic [2:0] {IDLE, ADDR, SNOOP, WB, MEM, DONE} state_t;
  state_t state;
  logic [1:0] last_owner, nxt1, nxt2, win;
  logic [2:0][1:0] cmds;
  logic [2:0][4:0] addrs;
  logic [2:0] elig;
  logic shr, shr_now, wb_any;
  assign cmds = {req_cmd2, req_cmd1, req_cmd0};
  assign addrs = {req_addr2, req_addr1, req_addr0};
  assign elig = req & {|req_cmd2, |req_cmd1, |req_cmd0};
  assign nxt1 = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
  assign nxt2 = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
  // Search order is last+1, last+2, then last itself.
  assign win = elig[nxt1] ? nxt1 : elig[nxt2] ? nxt2 : last_owner;
  assign shr_now = |(snoop_share & ~gnt);
  assign wb_any = |(snoop_wb & ~gnt);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_owner <= 2'd2;
      gnt <= '0;
      bus_owner <= '0;
      bus_valid <= 1'b0;
      bus_cmd <= '0;
      bus_addr <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      done <= '0;
      rdata <= '0;
      shared <= 1'b0;
      shr <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      mem_wr <= 1'b0;
      done <= '0;
      rdata <= '0;
      shared <= 1'b0;
      case (state)
        IDLE: if (|elig) begin
          state <= ADDR;
          gnt <= 3'b001 << win;
          bus_owner <= win;
          bus_cmd <= cmds[win];
          bus_addr <= addrs[win];
          bus_valid <= 1'b1;
        end
        ADDR: state <= SNOOP;
        SNOOP: begin
          shr <= shr_now;
          if (wb_any) begin
            state <= WB;
            mem_wr <= 1'b1;
            mem_addr <= bus_addr;
            mem_wdata <= wb_data;
          end else if (bus_cmd == 2'b11) begin
            state <= DONE;
            done <= gnt;
            shared <= shr_now;
          end else begin
            state <= MEM;
            mem_rd <= 1'b1;
            mem_addr <= bus_addr;
          end
        end
        WB: if (bus_cmd == 2'b11) begin
          state <= DONE;
          done <= gnt;
          shared <= shr;
        end else begin
          state <= MEM;
          mem_rd <= 1'b1;
        end
        MEM: if (mem_ack) begin
          state <= DONE;
          mem_rd <= 1'b0;
          done <= gnt;
          rdata <= mem_rdata;
          shared <= shr;
        end
        DONE: begin
          state <= IDLE;
          last_owner <= bus_owner;
          gnt <= '0;
          bus_owner <= '0;
          bus_cmd <= '0;
          bus_addr <= '0;
          mem_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
